// File: rtl/stcam_pkg.sv
// Shared STCAM definitions: default geometry and the lookup result record.
// The count field exists only when STCAM_MATCH_COUNT_EN is defined.
package stcam_pkg;

  localparam int STCAM_ROWS_DEF   = 16;
  localparam int STCAM_ADDR_W_DEF = 4;

  typedef struct packed {
    logic                        hit;
    logic                        multi;
    logic [STCAM_ADDR_W_DEF-1:0] addr;
`ifdef STCAM_MATCH_COUNT_EN
    logic [STCAM_ADDR_W_DEF:0]   count;
`endif
  } stcam_result_t;

endpackage

// File: rtl/stcam_prio_enc.sv
// Combinational lowest-set-bit encoder for the STCAM match lines.
// addr is 0 and hit is 0 when no line is set.
module stcam_prio_enc #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]   vec,
  output logic [ADDR_W-1:0] addr,
  output logic              hit
);

  assign hit = |vec;

  // Scan from the top down so the lowest set bit is the last to write addr.
  always_comb begin
    addr = {ADDR_W{1'b0}};
    for (int i = ROWS - 1; i >= 0; i--) begin
      addr = vec[i] ? ADDR_W'(i) : addr;
    end
  end

endmodule

// File: rtl/stcam_match_encoder.sv
// Two-stage match-line encoder: S1 captures the row vector, S2 registers the
// lowest matching row, hit/multi flags and (with STCAM_MATCH_COUNT_EN) a popcount.
module stcam_match_encoder
  import stcam_pkg::*;
#(
  parameter int ROWS   = STCAM_ROWS_DEF,
  parameter int ADDR_W = STCAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROWS-1:0]   match_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic              out_multi,
  output logic [ADDR_W-1:0] out_addr
`ifdef STCAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_W:0]   out_count
`endif
);

  localparam logic [ROWS-1:0] ONE = {{(ROWS-1){1'b0}}, 1'b1};

  logic              s1_valid;
  logic [ROWS-1:0]   s1_vec;
  logic              s1_load;
  logic              s2_load;
  logic [ADDR_W-1:0] enc_addr;
  logic              enc_hit;
  logic              enc_multi;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && !flush && (!s1_valid || s2_load);
  assign s1_load  = in_valid && in_ready;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign enc_multi = |(s1_vec & (s1_vec - ONE));

  stcam_prio_enc #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .vec  (s1_vec),
    .addr (enc_addr),
    .hit  (enc_hit)
  );

`ifdef STCAM_MATCH_COUNT_EN
  logic [ADDR_W:0] enc_count;

  // Population count of the captured vector; ADDR_W+1 bits hold 0..ROWS.
  always_comb begin
    enc_count = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < ROWS; i++) begin
      enc_count = enc_count + {{ADDR_W{1'b0}}, s1_vec[i]};
    end
  end
`endif

  // Pipeline registers; flush drops valids but leaves the data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_vec    <= {ROWS{1'b0}};
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_multi <= 1'b0;
      out_addr  <= {ADDR_W{1'b0}};
`ifdef STCAM_MATCH_COUNT_EN
      out_count <= {(ADDR_W+1){1'b0}};
`endif
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_vec   <= match_vec;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= s1_valid;
      end

      if (s2_load) begin
        out_valid <= 1'b1;
        out_hit   <= enc_hit;
        out_multi <= enc_multi;
        out_addr  <= enc_addr;
`ifdef STCAM_MATCH_COUNT_EN
        out_count <= enc_count;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_stcam_match_encoder.sv
// Self-checking bench for stcam_match_encoder: vector table, scoreboard queue
// and hand-written backpressure / flush / reset sequences.
module tb_stcam_match_encoder;

  typedef struct packed {
    logic       hit;
    logic       multi;
    logic [3:0] addr;
    logic [4:0] count;
  } exp_t;

  typedef struct {
    logic [15:0] vec;
    exp_t        exp;
  } vec_rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] match_vec;
  logic        out_valid;
  logic        out_ready;
  logic        out_hit;
  logic        out_multi;
  logic [3:0]  out_addr;
`ifdef STCAM_MATCH_COUNT_EN
  logic [4:0]  out_count;
`endif

  exp_t     sb[$];
  int       checks   = 0;
  int       failures = 0;
  vec_rec_t tbl[8];

  always #5 clk = ~clk;

  stcam_match_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .match_vec (match_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit   (out_hit),
    .out_multi (out_multi),
    .out_addr  (out_addr)
`ifdef STCAM_MATCH_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: scan upward, first set bit is the address.
  function automatic exp_t model(input logic [15:0] v);
    exp_t e;
    int   n;
    e = '0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        n++;
        if (!e.hit) begin
          e.hit  = 1'b1;
          e.addr = 4'(i);
        end
      end
    end
    e.multi = (n >= 2);
    e.count = 5'(n);
    return e;
  endfunction

  // Output monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_hit", 32'(out_hit), 32'(e.hit));
        check("out_multi", 32'(out_multi), 32'(e.multi));
        check("out_addr", 32'(out_addr), 32'(e.addr));
`ifdef STCAM_MATCH_COUNT_EN
        check("out_count", 32'(out_count), 32'(e.count));
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] v, input exp_t e, output int waits);
    waits     = 0;
    in_valid  = 1'b1;
    match_vec = v;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        break;
      end
      waits++;
      if (waits > 50) begin
        check("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_hit"}, 32'(out_hit), 32'd0);
    check({name, "_multi"}, 32'(out_multi), 32'd0);
    check({name, "_addr"}, 32'(out_addr), 32'd0);
`ifdef STCAM_MATCH_COUNT_EN
    check({name, "_count"}, 32'(out_count), 32'd0);
`endif
  endtask

  initial begin
    int w;
    logic [15:0] v;

    tbl[0] = '{16'h8100, '{1'b1, 1'b1, 4'd8,  5'd2}};
    tbl[1] = '{16'h0000, '{1'b0, 1'b0, 4'd0,  5'd0}};
    tbl[2] = '{16'h8000, '{1'b1, 1'b0, 4'd15, 5'd1}};
    tbl[3] = '{16'hFFFF, '{1'b1, 1'b1, 4'd0,  5'd16}};
    tbl[4] = '{16'h0024, '{1'b1, 1'b1, 4'd2,  5'd2}};
    tbl[5] = '{16'h0003, '{1'b1, 1'b1, 4'd0,  5'd2}};
    tbl[6] = '{16'h4000, '{1'b1, 1'b0, 4'd14, 5'd1}};
    tbl[7] = '{16'hF0F0, '{1'b1, 1'b1, 4'd4,  5'd8}};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    match_vec = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check_zero_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single search: two-cycle latency.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    match_vec = 16'h0004;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    sb.push_back('{1'b1, 1'b0, 4'd2, 5'd1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat2_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) send(tbl[i].vec, tbl[i].exp, w);
    drain("tbl_drain");

    // Backpressure: two accepts, third input stalls, output held.
    out_ready = 1'b0;
    send(16'h0010, model(16'h0010), w);
    send(16'h0300, model(16'h0300), w);
    in_valid  = 1'b1;
    match_vec = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_addr_hold", 32'(out_addr), 32'd4);
      check("bp_multi_hold", 32'(out_multi), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(16'h0001, model(16'h0001), w);
    drain("bp_drain");

    // Full streaming: no stall cycles.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      v = 16'h0001 << k;
      send(v, model(v), w);
      check("stream_waits", 32'(w), 32'd0);
    end
    drain("stream_drain");

    // Flush with two in flight, overriding a simultaneous out_ready.
    out_ready = 1'b0;
    send(16'h0020, model(16'h0020), w);
    send(16'h0040, model(16'h0040), w);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    match_vec = 16'h0001;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset mid-pipeline.
    out_ready = 1'b0;
    send(16'h0600, model(16'h0600), w);
    send(16'h0080, model(16'h0080), w);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check_zero_outputs("mrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random vectors under random backpressure.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          v = (i % 5 == 0) ? 16'h0000 : 16'($urandom);
          send(v, model(v), w);
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
